// File: rtl/multiplier_signed_if.sv
// Operand/product bundle for the registered signed multiplier.
// The master drives operands; the slave returns the registered product.
interface multiplier_signed_if #(
    parameter int A_WIDTH = 8,
    parameter int B_WIDTH = 4
);
    localparam int Y_WIDTH = A_WIDTH + B_WIDTH;

    logic signed [A_WIDTH-1:0] a;
    logic signed [B_WIDTH-1:0] b;
    logic signed [Y_WIDTH-1:0] y;

    modport master (
        output a,
        output b,
        input  y
    );

    modport slave (
        input  a,
        input  b,
        output y
    );
endinterface

// File: rtl/multiplier_signed.sv
// Registered two's-complement multiplier built from an explicit
// sign-extended partial-product array; one product per clock, latency 1.
module multiplier_signed #(
    parameter int A_WIDTH = 8,
    parameter int B_WIDTH = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    multiplier_signed_if.slave  bus
);
    localparam int Y_WIDTH = A_WIDTH + B_WIDTH;

    logic [Y_WIDTH-1:0] a_ext;
    logic [Y_WIDTH-1:0] pp  [B_WIDTH];
    logic [Y_WIDTH-1:0] sum [B_WIDTH+1];
    logic [Y_WIDTH-1:0] y_d;
    logic [Y_WIDTH-1:0] y_q;

    assign a_ext  = {{B_WIDTH{bus.a[A_WIDTH-1]}}, bus.a};
    assign sum[0] = '0;

    for (genvar i = 0; i < B_WIDTH; i++) begin : g_row
        if (i < B_WIDTH - 1) begin : g_pos
            assign pp[i] = bus.b[i] ? (a_ext << i) : '0;
        end else begin : g_neg
            // The sign bit of b carries weight -2^(B_WIDTH-1).
            assign pp[i] = bus.b[i] ? ('0 - (a_ext << i)) : '0;
        end
        assign sum[i+1] = sum[i] + pp[i];
    end

    assign y_d = sum[B_WIDTH];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            y_q <= '0;
        end else begin
            y_q <= y_d;
        end
    end

    assign bus.y = y_q;
endmodule

// File: tb/tb_multiplier_signed.sv
// Randomized and exhaustive checks of the 8x4 signed multiplier
// against an integer-arithmetic reference product.
module tb_multiplier_signed;
    localparam int AW = 8;
    localparam int BW = 4;
    localparam int YW = AW + BW;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    multiplier_signed_if #(.A_WIDTH(AW), .B_WIDTH(BW)) mif ();

    multiplier_signed #(.A_WIDTH(AW), .B_WIDTH(BW)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (mif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [YW-1:0] got,
                         input logic [YW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)",
                     tag, $signed(got), got, $signed(exp), exp);
        end
    endtask

    function automatic logic [YW-1:0] ref_mul(input int ia, input int ib);
        int p;
        p = ia * ib;
        return p[YW-1:0];
    endfunction

    task automatic drive(input int ia, input int ib);
        mif.a = ia[AW-1:0];
        mif.b = ib[BW-1:0];
    endtask

    task automatic apply(input string tag, input int ia, input int ib);
        @(negedge clk);
        drive(ia, ib);
        @(posedge clk);
        #1;
        check(tag, mif.y, ref_mul(ia, ib));
    endtask

    initial begin
        int ra;
        int rb;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b1;
        drive(5, 3);
        #1;
        rst_n = 1'b0;
        #1;
        check("reset_async", mif.y, '0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", mif.y, '0);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release", mif.y, ref_mul(5, 3));

        apply("zero", 0, 0);
        apply("pos_pos", 2, 3);
        apply("neg_pos", -2, 5);
        apply("pos_neg", 6, -3);
        apply("neg_neg", -5, -7);
        apply("min_min", -128, -8);
        apply("min_max", -128, 7);
        apply("max_min", 127, -8);
        apply("max_max", 127, 7);

        // Back-to-back random stream: new operands every cycle.
        @(negedge clk);
        for (int k = 0; k < 200; k++) begin
            ra = int'($urandom_range(255)) - 128;
            rb = int'($urandom_range(15)) - 8;
            drive(ra, rb);
            @(posedge clk);
            #1;
            check("stream", mif.y, ref_mul(ra, rb));
        end

        // Asynchronous reset mid-cycle must clear y without a clock edge.
        apply("pre_reset", 7, 3);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_midstream", mif.y, '0);
        @(posedge clk);
        #1;
        check("reset_mid_hold", mif.y, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_mid_release", mif.y, ref_mul(7, 3));

        for (int ia = -128; ia < 128; ia++) begin
            for (int ib = -8; ib < 8; ib++) begin
                apply("sweep", ia, ib);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
